// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed byte stream into
// big-endian words, writes them to memory, verifies an XOR checksum, and gates CPU reset.
module imem_loader #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded,
    output logic        cpu_hold
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] n_q, n_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] words_q, words_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic [15:0] len_rx;
    logic        len_overflow;
    logic [15:0] words_inc;

    // The loader is ready for bytes exactly while a load is in progress.
    assign busy   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign s_ready = busy;
    assign accept  = s_valid && s_ready;

    assign len_rx       = {len_hi_q, s_data};
    assign len_overflow = {14'd0, len_rx, 2'b00} > MEM_BYTES[31:0];
    assign words_inc    = words_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        word_d   = word_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        words_d  = words_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    words_d = 16'd0;
                    csum_d  = 8'd0;
                    idx_d   = 2'd0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = s_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    n_d = len_rx;
                    if (len_overflow)
                        state_d = ST_ERROR;
                    else if (len_rx == 16'd0)
                        state_d = ST_CHECK;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    word_d = {word_q[15:0], s_data};
                    csum_d = csum_q ^ s_data;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR[31:0] + {14'd0, words_q, 2'b00};
                        wdata_d = {word_q, s_data};
                        words_d = words_inc;
                        // Leaving DATA now means a byte taken during the write cycle is the checksum.
                        if (words_inc == n_q)
                            state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (accept)
                    state_d = (s_data == csum_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_hi_q <= 8'd0;
            n_q      <= 16'd0;
            word_q   <= 24'd0;
            idx_q    <= 2'd0;
            csum_q   <= 8'd0;
            words_q  <= 16'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            n_q      <= n_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            words_q  <= words_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign words_loaded = words_q;
    assign cpu_hold     = ~done;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames, a table of randomized frames
// checked against a frame-level reference model, and a mid-load reset sequence.
module tb_imem_loader;

    localparam int MEM = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;
    logic        cpu_hold;

    imem_loader #(.BASE_ADDR(0), .MEM_BYTES(MEM)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  frame_q[$];
    int          long_pulse = 0;
    logic        prev_we = 1'b0;

    // Write monitor: records every strobe and flags strobes wider than one cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            if (prev_we) long_pulse++;
        end
        prev_we = mem_we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        bit corrupt;
        int gap_max;
        bit start_mid;
        bit exp_done;
        bit exp_error;
    } vec_t;

    vec_t vecs[10];

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        long_pulse = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with s_valid low.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 8; i++) begin
            if (s_ready) begin
                @(posedge clk);
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max, input bit start_mid, output int accepted);
        bit ok;
        accepted = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (start_mid && i == 3) start = 1'b1;
            send_byte(frame_q[i], $urandom_range(gap_max, 0), ok);
            start = 1'b0;
            if (!ok) break;
            accepted++;
        end
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        cs = 8'd0;
        if (4 * n > MEM) begin
            for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                cs ^= b;
                frame_q.push_back(b);
            end
            frame_q.push_back(corrupt ? (cs ^ 8'h5A) : cs);
        end
    endtask

    // Reference model: interprets the frame as a whole and predicts accepted
    // byte count, words written and the exact write sequence.
    task automatic model(output int exp_acc, output int exp_words);
        int n;
        logic [31:0] w;
        exp_addr_q.delete();
        exp_data_q.delete();
        n = int'(frame_q[0]) * 256 + int'(frame_q[1]);
        if (4 * n > MEM) begin
            exp_acc   = 2;
            exp_words = 0;
        end else begin
            for (int k = 0; k < n; k++) begin
                w = {frame_q[2+4*k], frame_q[3+4*k], frame_q[4+4*k], frame_q[5+4*k]};
                exp_addr_q.push_back(32'(4 * k));
                exp_data_q.push_back(w);
            end
            exp_acc   = 3 + 4 * n;
            exp_words = n;
        end
    endtask

    task automatic run_frame(input string tag, input int gap_max, input bit start_mid,
                             input bit exp_done, input bit exp_error);
        int acc, exp_acc, exp_words;
        model(exp_acc, exp_words);
        clear_mon();
        pulse_start();
        send_frame(gap_max, start_mid, acc);
        repeat (3) @(negedge clk);
        chk({tag, "_accepted"}, 32'(acc), 32'(exp_acc));
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_error});
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, ~exp_done});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_words"}, {16'd0, words_loaded}, 32'(exp_words));
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        chk({tag, "_long_pulse"}, 32'(long_pulse), 32'd0);
        for (int k = 0; k < exp_addr_q.size() && k < wr_addr_q.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wr_addr_q[k], exp_addr_q[k]);
            chk($sformatf("%s_data%0d", tag, k), wr_data_q[k], exp_data_q[k]);
        end
        $display("frame %s: n=%0d accepted=%0d writes=%0d done=%0d error=%0d",
                 tag, exp_words, acc, wr_addr_q.size(), done, error);
    endtask

    task automatic load_test_frame(input logic [7:0] cs);
        logic [7:0] fr [11];
        fr = '{8'h00, 8'h02, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h20, 8'h01, 8'h13, 8'h00};
        fr[10] = cs;
        frame_q.delete();
        foreach (fr[i]) frame_q.push_back(fr[i]);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        int acc;
        bit ok;

        vecs[0] = '{2,    1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2,    1'b0, 3, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{3,    1'b1, 2, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{33,   1'b0, 1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{0,    1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32,   1'b0, 2, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1,    1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{5,    1'b0, 3, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{0,    1'b1, 0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1000, 1'b0, 0, 1'b0, 1'b0, 1'b1};

        // Reset state
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        // Directed N=2 load, continuous valid
        load_test_frame(8'hF1);
        run_frame("dir_ok", 0, 1'b0, 1'b1, 1'b0);
        chk("dir_w0_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hDEAD_BEEF, 32'h0000_0000);
        chk("dir_w0_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hDEAD_BEEF, 32'h0050_0093);
        chk("dir_w1_addr", (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hDEAD_BEEF, 32'h0000_0004);
        chk("dir_w1_data", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hDEAD_BEEF, 32'h0020_0113);

        // Same frame with random gaps, then with a bad checksum
        load_test_frame(8'hF1);
        run_frame("dir_gaps", 3, 1'b0, 1'b1, 1'b0);
        load_test_frame(8'hF0);
        run_frame("dir_badcs", 0, 1'b0, 1'b0, 1'b1);

        // Randomized table
        for (int v = 0; v < 10; v++) begin
            build_frame(vecs[v].n, vecs[v].corrupt);
            run_frame($sformatf("vec%0d", v), vecs[v].gap_max, vecs[v].start_mid,
                      vecs[v].exp_done, vecs[v].exp_error);
        end

        // Reset after 5 data bytes of a 2-word load
        load_test_frame(8'hF1);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(frame_q[i], 0, ok);
        chk("midrst_pre_words", {16'd0, words_loaded}, 32'd1);
        chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("midrst");
        chk("midrst_nwrites", 32'(wr_addr_q.size()), 32'd1);
        chk("midrst_w0_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hDEAD_BEEF, 32'h0);
        $display("midload reset: writes before reset=%0d", wr_addr_q.size());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_test_frame(8'hF1);
        run_frame("post_rst", 1, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so a stuck DUT can never hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
